// File: rtl/flash_pkg.sv
// ============================================================================
// Module : flash_pkg
// Purpose: Shared types and constants for the flash lamp sequencer: the
//          sequencer state encoding, the kickback points and the per-segment
//          lamp-count targets, plus small helpers describing each segment.
// Ports  : none (package)
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package flash_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_UP6  = 3'd1,
    S_DN0  = 3'd2,
    S_UP11 = 3'd3,
    S_DN5  = 3'd4,
    S_UP16 = 3'd5,
    S_DN0B = 3'd6
  } state_t;

  // Lamp counts at which a held flick can kick an up-ramp back down.
  localparam int KICK_LO = 6;
  localparam int KICK_HI = 11;

  // Lamp count at which each segment ends.
  localparam int TGT_UP6  = 6;
  localparam int TGT_DN0  = 0;
  localparam int TGT_UP11 = 11;
  localparam int TGT_DN5  = 5;
  localparam int TGT_UP16 = 16;
  localparam int TGT_DN0B = 0;

  function automatic int seg_target(input state_t s);
    case (s)
      S_UP6:   return TGT_UP6;
      S_DN0:   return TGT_DN0;
      S_UP11:  return TGT_UP11;
      S_DN5:   return TGT_DN5;
      S_UP16:  return TGT_UP16;
      S_DN0B:  return TGT_DN0B;
      default: return 0;
    endcase
  endfunction

  function automatic logic is_up(input state_t s);
    return (s == S_UP6) || (s == S_UP11) || (s == S_UP16);
  endfunction

  // Segment that follows when a segment reaches its target. An illegal
  // encoding falls back to IDLE so the sequencer always recovers.
  function automatic state_t seg_next(input state_t s);
    case (s)
      S_UP6:   return S_DN0;
      S_DN0:   return S_UP11;
      S_UP11:  return S_DN5;
      S_DN5:   return S_UP16;
      S_UP16:  return S_DN0B;
      S_DN0B:  return S_UP6;
      default: return S_IDLE;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/step_prescaler.sv
// ============================================================================
// Module : step_prescaler
// Purpose: Divides clk into a one-cycle step strobe every STEP_DIV cycles.
//          While hold is high the count is parked at 0, so the first strobe
//          after hold drops arrives exactly STEP_DIV cycles later.
// Ports  : clk  - clock (rising edge)
//          rst  - synchronous active-high reset
//          hold - keep the divider cleared (sequencer idle)
//          step - strobe, high on the cycle the count equals STEP_DIV-1
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module step_prescaler #(
  parameter int STEP_DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic hold,
  output logic step
);

  localparam logic [15:0] TERM = 16'(STEP_DIV - 1);

  logic [15:0] div_q;

  assign step = !hold && (div_q == TERM);

  always_ff @(posedge clk) begin
    if (rst || hold) begin
      div_q <= '0;
    end else if (div_q == TERM) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + 16'd1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/flash_seq_ctrl.sv
// ============================================================================
// Module : flash_seq_ctrl
// Purpose: Lamp-bar flash sequencer. A flick starts a looping ramp pattern
//          0->6->0->11->5->16->0 of lit lamps; a flick held while ramping up
//          through 6 or 11 in the longer ramps kicks the bar back down.
// Ports  : clk   - clock (rising edge)
//          rst   - synchronous active-high reset
//          flick - start / kickback request
//          lamps - registered thermometer code of the lit-lamp count
//          state - registered sequencer state (debug)
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module flash_seq_ctrl #(
  parameter int LAMP_N   = 16,
  parameter int STEP_DIV = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flick,
  output logic [LAMP_N-1:0] lamps,
  output logic [2:0]        state
);

  import flash_pkg::*;

  localparam int CW = $clog2(LAMP_N + 1);

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [LAMP_N-1:0] lamps_q, lamps_d;
  logic              step;
  logic              kick_pt;

  step_prescaler #(
    .STEP_DIV (STEP_DIV)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .hold (state_q == S_IDLE),
    .step (step)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      lamps_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lamps_q <= lamps_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    kick_pt = 1'b0;

    if (state_q == S_IDLE) begin
      // Leaving idle only arms the ramp; the first lamp lights on a step.
      if (flick) state_d = S_UP6;
    end else if (step) begin
      // Saturating move keeps the count inside 0..LAMP_N.
      if (is_up(state_q)) begin
        if (cnt_q != CW'(LAMP_N)) cnt_d = cnt_q + 1'b1;
      end else begin
        if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
      end

      kick_pt = (cnt_d == CW'(KICK_LO)) || (cnt_d == CW'(KICK_HI));

      // Kickback takes priority over the normal end-of-segment advance.
      if (flick && kick_pt && (state_q == S_UP11)) begin
        state_d = S_DN0;
      end else if (flick && kick_pt && (state_q == S_UP16)) begin
        state_d = S_DN5;
      end else if (cnt_d == CW'(seg_target(state_q))) begin
        state_d = seg_next(state_q);
      end
    end

    // Decode from the next count so lamps track cnt on the same edge.
    lamps_d = '0;
    for (int i = 0; i < LAMP_N; i++) begin
      lamps_d[i] = (i < int'(cnt_d));
    end
  end

  assign lamps = lamps_q;
  assign state = state_q;

endmodule

`default_nettype wire

// File: tb/tb_flash_seq_ctrl.sv
// ============================================================================
// Module : tb_flash_seq_ctrl
// Purpose: Self-checking bench for flash_seq_ctrl. Two instances (STEP_DIV=1
//          and STEP_DIV=4) share rst/flick and are compared every cycle
//          against a table-driven reference model, plus directed scenario
//          checks derived from the expected lamp patterns.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_flash_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        flick;
  logic [15:0] lamps1, lamps4;
  logic [2:0]  state1, state4;

  int checks = 0;
  int errors = 0;

  // Reference model: segment tables indexed by state number.
  int tgt [7] = '{0, 6, 0, 11, 5, 16, 0};
  int nxt [7] = '{0, 2, 3, 4, 5, 6, 1};
  int upd [7] = '{0, 1, -1, 1, -1, 1, -1};

  int m1_st, m1_c;
  int m4_st, m4_c, m4_pre;

  always #5 clk = ~clk;

  flash_seq_ctrl #(.LAMP_N(16), .STEP_DIV(1)) dut1 (
    .clk(clk), .rst(rst), .flick(flick), .lamps(lamps1), .state(state1)
  );

  flash_seq_ctrl #(.LAMP_N(16), .STEP_DIV(4)) dut4 (
    .clk(clk), .rst(rst), .flick(flick), .lamps(lamps4), .state(state4)
  );

  function automatic logic [15:0] therm(input int c);
    logic [31:0] v;
    v = (32'd1 << c) - 32'd1;
    return v[15:0];
  endfunction

  function automatic void model_edge(input bit r, input bit f, input bit stp,
                                     inout int st, inout int c);
    if (r) begin
      st = 0;
      c  = 0;
    end else if (st == 0) begin
      if (f) st = 1;
    end else if (stp) begin
      c = c + upd[st];
      if (f && (st == 3) && (c == 6 || c == 11))      st = 2;
      else if (f && (st == 5) && (c == 6 || c == 11)) st = 4;
      else if (c == tgt[st])                          st = nxt[st];
    end
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input bit r, input bit f);
    bit stp4;
    rst   = r;
    flick = f;
    @(posedge clk);
    stp4 = (m4_st != 0) && (m4_pre == 3);
    if (r || m4_st == 0) m4_pre = 0;
    else                 m4_pre = (m4_pre == 3) ? 0 : m4_pre + 1;
    model_edge(r, f, (m1_st != 0), m1_st, m1_c);
    model_edge(r, f, stp4, m4_st, m4_c);
    #1;
    check("lamps_div1", lamps1, therm(m1_c));
    check("state_div1", {13'd0, state1}, 16'(m1_st));
    check("lamps_div4", lamps4, therm(m4_c));
    check("state_div4", {13'd0, state4}, 16'(m4_st));
  endtask

  initial begin
    logic [15:0] exp_q[$];
    logic [15:0] prev4, max1, min1;
    int          last4, n4, budget;

    m1_st = 0; m1_c = 0; m4_st = 0; m4_c = 0; m4_pre = 0;
    rst = 1'b1; flick = 1'b0;

    // Reset for 3 cycles, then idle with flick low.
    for (int i = 0; i < 3; i++) tick(1, 0);
    check("reset_lamps", lamps1, 16'h0000);
    check("reset_state", {13'd0, state1}, 16'd0);
    for (int i = 0; i < 20; i++) begin
      tick(0, 0);
      check("idle_lamps", lamps1, 16'h0000);
      check("idle_state4", {13'd0, state4}, 16'd0);
    end

    // Single flick pulse: full 56-step pattern, then back to UP6.
    for (int c = 1;  c <= 6;  c++) exp_q.push_back(therm(c));
    for (int c = 5;  c >= 0;  c--) exp_q.push_back(therm(c));
    for (int c = 1;  c <= 11; c++) exp_q.push_back(therm(c));
    for (int c = 10; c >= 5;  c--) exp_q.push_back(therm(c));
    for (int c = 6;  c <= 16; c++) exp_q.push_back(therm(c));
    for (int c = 15; c >= 0;  c--) exp_q.push_back(therm(c));
    tick(0, 1);
    check("arm_lamps", lamps1, 16'h0000);
    check("arm_state", {13'd0, state1}, 16'd1);
    prev4 = lamps4; last4 = 0; n4 = 0;
    for (int k = 1; k <= 56; k++) begin
      tick(0, 0);
      check("seq_lamps", lamps1, exp_q[k-1]);
      if (lamps4 !== prev4) begin
        check("div4_gap", 16'(k - last4), 16'd4);
        last4 = k; prev4 = lamps4; n4++;
      end
    end
    check("div4_changes", 16'(n4), 16'd14);
    check("loop_state", {13'd0, state1}, 16'd1);
    check("loop_lamps", lamps1, 16'h0000);
    tick(0, 0);
    check("loop_restart", lamps1, 16'h0001);

    // Flick held high: bar oscillates between 0 and 0x3F.
    tick(1, 0);
    max1 = '0;
    for (int i = 0; i < 100; i++) begin
      tick(0, 1);
      if (lamps1 > max1) max1 = lamps1;
    end
    check("held_max", max1, 16'h003F);

    // Kick UP16 at 11 lamps: down to 5, then up to 16 with flick low.
    tick(1, 0);
    tick(0, 1);
    budget = 300;
    while (!(m1_st == 5 && m1_c == 10) && budget > 0) begin
      tick(0, 0);
      budget--;
    end
    tick(0, 1);
    check("kick_lamps", lamps1, 16'h07FF);
    check("kick_state", {13'd0, state1}, 16'd4);
    min1 = 16'hFFFF;
    budget = 40;
    while (lamps1 !== 16'hFFFF && budget > 0) begin
      tick(0, 0);
      if (lamps1 < min1) min1 = lamps1;
      budget--;
    end
    check("kick_min", min1, 16'h001F);
    check("kick_full", lamps1, 16'hFFFF);
    check("kick_full_state", {13'd0, state1}, 16'd6);

    // Reset mid-UP16 at 0xFF.
    tick(1, 0);
    tick(0, 1);
    budget = 300;
    while (!(m1_st == 5 && m1_c == 8) && budget > 0) begin
      tick(0, 0);
      budget--;
    end
    check("pre_rst_lamps", lamps1, 16'h00FF);
    tick(1, 0);
    check("mid_rst_lamps", lamps1, 16'h0000);
    check("mid_rst_state", {13'd0, state1}, 16'd0);
    for (int i = 0; i < 10; i++) begin
      tick(0, 0);
      check("post_rst_idle", {13'd0, state1}, 16'd0);
    end

    // Randomized flick and occasional reset against the model.
    for (int i = 0; i < 400; i++) begin
      tick(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
